// File: rtl/cpu_prog_loader_if.sv
// Byte-stream input link plus CPU load port of the program loader.
// The slave side is the loader; the master side is the pad ring / CPU harness.
interface cpu_prog_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] instr;
    logic              data_or_reg;
    logic              wr;
    logic              run;
    logic              busy;
    logic              err;

    modport master (
        output byte_data, byte_valid,
        input  byte_ready, address, instr, data_or_reg, wr, run, busy, err
    );

    modport slave (
        input  byte_data, byte_valid,
        output byte_ready, address, instr, data_or_reg, wr, run, busy, err
    );
endinterface

// File: rtl/cpu_prog_loader.sv
// Framed byte-stream program loader: turns payload bytes into CPU load strobes,
// gates CPU run enable, flags checksum and inter-byte timeout errors.
//
// state   | meaning
// IDLE    | CPU stopped, waiting for a header
// LEN     | LOAD header taken, waiting for the length byte
// PAYLOAD | each accepted byte becomes one write strobe
// CHECK   | waiting for the XOR checksum byte
// RUN     | CPU released, only HALT/LOAD headers act
module cpu_prog_loader #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             resetn,
    cpu_prog_loader_if.slave lp
);
    localparam int CNT_W = ((DATA_W > ADDR_W) ? DATA_W : ADDR_W) + 1;
    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(2 ** ADDR_W);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);

    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_RSVD = 2'b01;
    localparam logic [1:0] CMD_HALT = 2'b10;
    localparam logic [1:0] CMD_GO   = 2'b11;

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHECK, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              sel;
    logic [DATA_W-1:0] chk;
    logic [CNT_W-1:0]  count;
    logic [TMR_W-1:0]  tmr;

    logic [ADDR_W-1:0] address_q;
    logic [DATA_W-1:0] instr_q;
    logic              dor_q;
    logic              wr_q;
    logic              run_q;
    logic              busy_q;
    logic              err_q;

    logic       accept;
    logic [1:0] cmd;
    logic       in_frame;
    logic       load_hdr;
    logic       timeout;

    // No backpressure: ready simply follows reset release.
    assign lp.byte_ready = resetn;
    assign accept   = lp.byte_valid;
    assign cmd      = lp.byte_data[DATA_W-2 -: 2];
    assign in_frame = (state == LEN) || (state == PAYLOAD) || (state == CHECK);
    assign load_hdr = accept && (cmd == CMD_LOAD) && ((state == IDLE) || (state == RUN));
    assign timeout  = in_frame && !accept && (tmr == '0);

    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            addr      <= '0;
            sel       <= 1'b0;
            chk       <= '0;
            count     <= '0;
            tmr       <= TMR_LOAD;
            address_q <= '0;
            instr_q   <= '0;
            dor_q     <= 1'b0;
            wr_q      <= 1'b0;
            run_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_q <= 1'b0;

            // Down-counter of idle cycles left; reloaded by every accepted byte.
            if (accept) begin
                tmr <= TMR_LOAD;
            end else if (in_frame && (tmr != '0)) begin
                tmr <= tmr - TMR_W'(1);
            end

            if (load_hdr) begin
                sel    <= lp.byte_data[DATA_W-1];
                addr   <= lp.byte_data[ADDR_W-1:0];
                chk    <= lp.byte_data;
                err_q  <= 1'b0;
                busy_q <= 1'b1;
                run_q  <= 1'b0;
                state  <= LEN;
            end else if (timeout) begin
                err_q  <= 1'b1;
                busy_q <= 1'b0;
                state  <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            if (cmd == CMD_GO) begin
                                run_q <= 1'b1;
                                state <= RUN;
                            end else if (cmd == CMD_RSVD) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    LEN: begin
                        if (accept) begin
                            count <= (lp.byte_data == '0) ? FULL_CNT : CNT_W'(lp.byte_data);
                            chk   <= chk ^ lp.byte_data;
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        if (accept) begin
                            wr_q      <= 1'b1;
                            address_q <= addr;
                            instr_q   <= lp.byte_data;
                            dor_q     <= sel;
                            chk       <= chk ^ lp.byte_data;
                            addr      <= addr + ADDR_W'(1);
                            count     <= count - CNT_W'(1);
                            if (count == CNT_W'(1)) begin
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (accept) begin
                            if (lp.byte_data != chk) begin
                                err_q <= 1'b1;
                            end
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                    RUN: begin
                        if (accept && (cmd == CMD_HALT)) begin
                            run_q <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign lp.address     = address_q;
    assign lp.instr       = instr_q;
    assign lp.data_or_reg = dor_q;
    assign lp.wr          = wr_q;
    assign lp.run         = run_q;
    assign lp.busy        = busy_q;
    assign lp.err         = err_q;
endmodule

// File: tb/tb_cpu_prog_loader.sv
// Directed bench for cpu_prog_loader: a write scoreboard built from the frames
// the bench sends, checked every cycle, plus hand-computed status expectations.
module tb_cpu_prog_loader;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int TMO    = 4;

    typedef struct {
        int         due;
        logic [4:0] addr;
        logic [7:0] data;
        logic       sel;
    } wr_t;

    logic clk_i  = 1'b0;
    logic resetn = 1'b0;

    cpu_prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) lp ();

    cpu_prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
        .clk_i  (clk_i),
        .resetn (resetn),
        .lp     (lp)
    );

    always #5 clk_i = ~clk_i;

    int         checks   = 0;
    int         errors   = 0;
    int         edge_cnt = 0;
    wr_t        exp_q[$];
    logic [7:0] pl_q[$];
    logic [4:0] last_addr = '0;
    logic [7:0] last_data = '0;
    logic       last_sel  = 1'b0;

    always @(posedge clk_i) edge_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle: strobe timing/contents against the scoreboard, held values otherwise.
    always @(negedge clk_i) begin
        logic exp_wr;
        exp_wr = (exp_q.size() > 0) && (exp_q[0].due == edge_cnt);
        check("wr", lp.wr, exp_wr);
        if (exp_wr) begin
            last_addr = exp_q[0].addr;
            last_data = exp_q[0].data;
            last_sel  = exp_q[0].sel;
            void'(exp_q.pop_front());
        end
        check("address", lp.address, last_addr);
        check("instr", lp.instr, last_data);
        check("data_or_reg", lp.data_or_reg, last_sel);
        check("byte_ready", lp.byte_ready, resetn);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [7:0] b);
        lp.byte_data  = b;
        lp.byte_valid = 1'b1;
        step();
        lp.byte_valid = 1'b0;
    endtask

    task automatic drive_pl(input logic [7:0] b, input logic [4:0] a, input logic s);
        wr_t w;
        w.due  = edge_cnt + 1;
        w.addr = a;
        w.data = b;
        w.sel  = s;
        exp_q.push_back(w);
        drive(b);
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] hdr, input logic [7:0] n);
        logic [7:0] x;
        x = hdr ^ n;
        foreach (pl_q[i]) x ^= pl_q[i];
        return x;
    endfunction

    task automatic send_frame(input logic [7:0] hdr, input logic [7:0] n, input logic [7:0] cb);
        logic [4:0] a;
        int         cnt;
        a   = hdr[4:0];
        cnt = (n == 8'h00) ? 32 : int'(n);
        drive(hdr);
        check("busy_after_hdr", lp.busy, 1);
        drive(n);
        for (int i = 0; i < cnt; i++) begin
            drive_pl(pl_q[i], a, hdr[7]);
            a++;
        end
        check("busy_in_check", lp.busy, 1);
        drive(cb);
        check("busy_after_chk", lp.busy, 0);
    endtask

    initial begin
        lp.byte_data  = '0;
        lp.byte_valid = 1'b0;
        #12;
        check("rst_wr", lp.wr, 0);
        check("rst_run", lp.run, 0);
        check("rst_busy", lp.busy, 0);
        check("rst_err", lp.err, 0);
        check("rst_ready", lp.byte_ready, 0);
        step();
        resetn = 1'b1;
        step();

        // Test 1: basic LOAD, checksum 0xFE
        pl_q.delete(); pl_q.push_back(8'hA5); pl_q.push_back(8'h5A);
        send_frame(8'h03, 8'h02, 8'hFE);
        check("t1_err", lp.err, 0);
        check("t1_run", lp.run, 0);

        // Test 2: sel=1, address wrap 31 -> 0 -> 1, checksum 0x9C
        pl_q.delete(); pl_q.push_back(8'h11); pl_q.push_back(8'h22); pl_q.push_back(8'h33);
        send_frame(8'h9F, 8'h03, 8'h9C);
        check("t2_err", lp.err, 0);

        // Test 3: N=0 means 32 bytes covering the whole address space
        pl_q.delete();
        for (int i = 0; i < 32; i++) pl_q.push_back(8'((i * 7 + 3) & 8'hFF));
        send_frame(8'h00, 8'h00, xsum(8'h00, 8'h00));
        check("t3_err", lp.err, 0);

        // Test 4: bad checksum still writes, err sticky until next LOAD header
        pl_q.delete(); pl_q.push_back(8'hA5); pl_q.push_back(8'h5A);
        send_frame(8'h03, 8'h02, 8'h00);
        check("t4_err_set", lp.err, 1);
        drive(8'h40);
        check("t4_err_sticky", lp.err, 1);
        drive(8'h05);
        check("t4_err_clr", lp.err, 0);
        drive(8'h01);
        drive_pl(8'h77, 5'd5, 1'b0);
        drive(8'h73);
        check("t4b_err", lp.err, 0);
        check("t4b_busy", lp.busy, 0);

        // Reserved command in IDLE raises err
        drive(8'h20);
        check("rsvd_err", lp.err, 1);
        check("rsvd_busy", lp.busy, 0);

        // Test 5a: stall after length; TMO idle cycles tolerated, next idle aborts
        drive(8'h01);
        check("t5_err_clr", lp.err, 0);
        drive(8'h02);
        repeat (TMO) step();
        check("t5_busy_hold", lp.busy, 1);
        check("t5_err_hold", lp.err, 0);
        step();
        check("t5_busy_abort", lp.busy, 0);
        check("t5_err_abort", lp.err, 1);
        drive(8'h40);
        check("t5_idle_busy", lp.busy, 0);
        check("t5_idle_run", lp.run, 0);

        // Test 5b: bytes landing exactly in the timeout cycle win
        drive(8'h02);
        drive(8'h01);
        repeat (TMO) step();
        drive_pl(8'h44, 5'd2, 1'b0);
        check("t5b_busy", lp.busy, 1);
        check("t5b_err", lp.err, 0);
        repeat (TMO) step();
        drive(8'h47);
        check("t5b_busy_end", lp.busy, 0);
        check("t5b_err_end", lp.err, 0);

        // Test 6: GO / ignored headers / HALT / LOAD from RUN / reset mid-payload
        drive(8'h60);
        check("t6_go_run", lp.run, 1);
        check("t6_go_busy", lp.busy, 0);
        drive(8'h20);
        check("t6_rsvd_run", lp.run, 1);
        check("t6_rsvd_err", lp.err, 0);
        drive(8'h40);
        check("t6_halt_run", lp.run, 0);
        drive(8'h60);
        check("t6_go2_run", lp.run, 1);
        drive(8'h08);
        check("t6_load_run", lp.run, 0);
        check("t6_load_busy", lp.busy, 1);
        drive(8'h04);
        drive_pl(8'hC1, 5'd8, 1'b0);
        drive_pl(8'hC2, 5'd9, 1'b0);
        exp_q.delete();
        last_addr = '0;
        last_data = '0;
        last_sel  = 1'b0;
        resetn    = 1'b0;
        #1;
        check("t6_rst_wr", lp.wr, 0);
        check("t6_rst_busy", lp.busy, 0);
        check("t6_rst_address", lp.address, 0);
        check("t6_rst_instr", lp.instr, 0);
        repeat (2) step();
        resetn = 1'b1;
        repeat (3) step();
        check("t6_post_run", lp.run, 0);
        check("t6_post_busy", lp.busy, 0);
        check("t6_post_err", lp.err, 0);

        // Loader works normally after the mid-frame reset
        pl_q.delete(); pl_q.push_back(8'h5A);
        send_frame(8'h81, 8'h01, 8'hDA);
        check("post_err", lp.err, 0);

        repeat (2) step();
        check("pending_writes", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
